// File: rtl/fetch_sm_arbiter.sv
// Shares one I-cache port among NUM_SM fetch front-ends: round-robin PC arbitration,
// in-order tag FIFO, per-SM response slots. Optional counters: FETCH_ARB_PERF_CNT_EN.
module fetch_sm_arbiter #(
   parameter int NUM_SM     = 4,
   parameter int SM_LOG     = 2,
   parameter int PC_W       = 32,
   parameter int INST_W     = 64,
   parameter int WARP_LOG   = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_LOG   = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_SM-1:0]                 req_valid_i,
   output logic [NUM_SM-1:0]                 req_ready_o,
   input  logic [NUM_SM*PC_W-1:0]            req_pc_i,
   input  logic [NUM_SM*WARP_LOG-1:0]        req_warp_i,
   input  logic [NUM_SM-1:0]                 stall_i,
   output logic [PC_W-1:0]                   PC_o,
   output logic [PC_W-1:0]                   PCadd1_o,
   output logic                              cache_req_valid_o,
   input  logic                              cache_req_ready_i,
   input  logic                              cache_rsp_valid_i,
   input  logic [INST_W-1:0]                 instruction0_i,
   input  logic [INST_W-1:0]                 instruction1_i,
   output logic [NUM_SM-1:0]                 rsp_valid_o,
   output logic [NUM_SM*WARP_LOG-1:0]        rsp_warp_o,
   output logic [NUM_SM*(INST_W+PC_W)-1:0]   instPacket0_o,
   output logic [NUM_SM*(INST_W+PC_W)-1:0]   instPacket1_o,
   output logic [SM_LOG-1:0]                 grantSM_o,
   output logic [FIFO_LOG:0]                 inflight_o,
   output logic                              err_o
`ifdef FETCH_ARB_PERF_CNT_EN
   ,
   output logic [NUM_SM*32-1:0]              perf_grant_o,
   output logic [NUM_SM*32-1:0]              perf_stall_o
`endif
);

   localparam int PKT_W = INST_W + PC_W;
   localparam int TAG_W = SM_LOG + WARP_LOG + PC_W;

   logic [SM_LOG-1:0]   rrPtr;
   logic [NUM_SM-1:0]   pending;
   logic [NUM_SM-1:0]   eligible;
   logic [NUM_SM-1:0]   consume;

   logic                reqValid;
   logic [SM_LOG-1:0]   reqSm;
   logic [WARP_LOG-1:0] reqWarp;
   logic [PC_W-1:0]     reqPc;
   logic [PC_W-1:0]     reqPcAdd1;

   logic                canGrant;
   logic                reqDrain;
   logic                grantHit;
   logic [SM_LOG-1:0]   grantIdx;
   logic [SM_LOG-1:0]   candIdx;
   logic [WARP_LOG-1:0] grantWarp;
   logic [PC_W-1:0]     grantPc;

   logic [TAG_W-1:0]    tagMem [FIFO_DEPTH];
   logic [FIFO_LOG-1:0] wrPtr;
   logic [FIFO_LOG-1:0] rdPtr;
   logic [FIFO_LOG:0]   fifoCount;
   logic                pushEn;
   logic                popEn;
   logic [SM_LOG-1:0]   headSm;
   logic [WARP_LOG-1:0] headWarp;
   logic [PC_W-1:0]     headPc;

   assign eligible = req_valid_i & ~pending;
   assign consume  = rsp_valid_o & ~stall_i;
   assign reqDrain = reqValid & cache_req_ready_i;
   assign pushEn   = reqDrain;
   assign popEn    = cache_rsp_valid_i & (fifoCount != '0);

   // Gated by reset so req_ready_o reads zero while reset is held.
   assign canGrant = reset & (~reqValid | reqDrain)
                   & ((int'(fifoCount) + int'(reqValid)) < FIFO_DEPTH);

   always_comb begin
      grantHit = 1'b0;
      grantIdx = '0;
      candIdx  = '0;
      for (int i = 0; i < NUM_SM; i++) begin
         candIdx = SM_LOG'((int'(rrPtr) + i) % NUM_SM);
         if (!grantHit && canGrant && eligible[candIdx]) begin
            grantHit = 1'b1;
            grantIdx = candIdx;
         end
      end
   end

   always_comb begin
      grantWarp   = '0;
      grantPc     = '0;
      req_ready_o = '0;
      for (int j = 0; j < NUM_SM; j++) begin
         if (grantHit && grantIdx == SM_LOG'(j)) begin
            grantWarp      = req_warp_i[j*WARP_LOG +: WARP_LOG];
            grantPc        = req_pc_i[j*PC_W +: PC_W];
            req_ready_o[j] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rrPtr     <= '0;
         pending   <= '0;
         grantSM_o <= '0;
         reqValid  <= 1'b0;
         reqSm     <= '0;
         reqWarp   <= '0;
         reqPc     <= '0;
         reqPcAdd1 <= '0;
      end else begin
         pending <= (pending & ~consume) | req_ready_o;
         if (grantHit) begin
            rrPtr     <= SM_LOG'((int'(grantIdx) + 1) % NUM_SM);
            grantSM_o <= grantIdx;
            reqValid  <= 1'b1;
            reqSm     <= grantIdx;
            reqWarp   <= grantWarp;
            reqPc     <= grantPc;
            reqPcAdd1 <= grantPc + PC_W'(1);
         end else if (reqDrain) begin
            reqValid <= 1'b0;
         end
      end
   end

   assign cache_req_valid_o = reqValid;
   assign PC_o              = reqPc;
   assign PCadd1_o          = reqPcAdd1;

   // Tag storage needs no reset: only entries between rdPtr and wrPtr are ever read.
   always_ff @(posedge clk) begin
      if (pushEn) tagMem[wrPtr] <= {reqSm, reqWarp, reqPc};
   end

   assign {headSm, headWarp, headPc} = tagMem[rdPtr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         err_o     <= 1'b0;
      end else begin
         if (pushEn) wrPtr <= wrPtr + FIFO_LOG'(1);
         if (popEn)  rdPtr <= rdPtr + FIFO_LOG'(1);
         if (pushEn && !popEn)
            fifoCount <= fifoCount + (FIFO_LOG+1)'(1);
         else if (popEn && !pushEn)
            fifoCount <= fifoCount - (FIFO_LOG+1)'(1);
         if (cache_rsp_valid_i && fifoCount == '0) err_o <= 1'b1;
      end
   end

   assign inflight_o = fifoCount;

   // One outstanding request per SM, so a load never collides with a held slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_o   <= '0;
         rsp_warp_o    <= '0;
         instPacket0_o <= '0;
         instPacket1_o <= '0;
      end else begin
         for (int j = 0; j < NUM_SM; j++) begin
            if (popEn && headSm == SM_LOG'(j)) begin
               rsp_valid_o[j]                          <= 1'b1;
               rsp_warp_o[j*WARP_LOG +: WARP_LOG]      <= headWarp;
               instPacket0_o[j*PKT_W +: PKT_W]         <= {instruction0_i, headPc};
               instPacket1_o[j*PKT_W +: PKT_W]         <= {instruction1_i, headPc + PC_W'(1)};
            end else if (consume[j]) begin
               rsp_valid_o[j] <= 1'b0;
            end
         end
      end
   end

`ifdef FETCH_ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_grant_o <= '0;
         perf_stall_o <= '0;
      end else begin
         for (int j = 0; j < NUM_SM; j++) begin
            if (req_ready_o[j] && perf_grant_o[j*32 +: 32] != 32'hFFFF_FFFF)
               perf_grant_o[j*32 +: 32] <= perf_grant_o[j*32 +: 32] + 32'd1;
            if (rsp_valid_o[j] && stall_i[j] && perf_stall_o[j*32 +: 32] != 32'hFFFF_FFFF)
               perf_stall_o[j*32 +: 32] <= perf_stall_o[j*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/fetch_sm_arbiter.md
Name: fetch_sm_arbiter

Overview:
- Parametrised successor to the 4-SM fetch mux: NUM_SM fetch front-ends share one instruction-cache port.
- Round-robin arbitration of PC requests; tracks in-flight requests in an in-order tag FIFO; routes each cache response to the owning SM's registered response slot.
- Sits between the per-SM Fetch units and the shared I-cache.

Parameters:
NUM_SM, 4, number of SM fetch front-ends (≥2)
SM_LOG, 2, clog2(NUM_SM)
PC_W, 32, PC width
INST_W, 64, instruction width
WARP_LOG, 3, warp-id width
FIFO_DEPTH, 4, max in-flight cache requests (power of 2)
FIFO_LOG, 2, clog2(FIFO_DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid_i  in  NUM_SM  per-SM fetch request
req_ready_o  out  NUM_SM  per-SM request accepted (one-hot or zero)
req_pc_i  in  NUM_SM*PC_W  per-SM PC, SM i at bits [i*PC_W +: PC_W]
req_warp_i  in  NUM_SM*WARP_LOG  per-SM warp id
stall_i  in  NUM_SM  per-SM downstream stall
PC_o  out  PC_W  cache request PC
PCadd1_o  out  PC_W  PC_o+1, modulo 2^PC_W
cache_req_valid_o  out  1  cache request valid
cache_req_ready_i  in  1  cache accepts request
cache_rsp_valid_i  in  1  cache response, in request order, cannot be stalled
instruction0_i  in  INST_W  instruction at PC
instruction1_i  in  INST_W  instruction at PC+1
rsp_valid_o  out  NUM_SM  per-SM response valid
rsp_warp_o  out  NUM_SM*WARP_LOG  per-SM response warp
instPacket0_o  out  NUM_SM*(INST_W+PC_W)  {instruction0, PC}
instPacket1_o  out  NUM_SM*(INST_W+PC_W)  {instruction1, PC+1}
grantSM_o  out  SM_LOG  SM of last accepted request
inflight_o  out  FIFO_LOG+1  in-flight count
err_o  out  1  sticky: response received with FIFO empty

Behaviour:
- Reset (async, reset=0): every output 0; rr pointer=0; pending[]=0; FIFO empty; request register empty; err_o=0. Reset mid-operation discards in-flight state immediately.
- Eligible SM i: req_valid_i[i] & ~pending[i].
- Grant is issued only when the request register is empty or being drained this cycle (cache_req_valid_o & cache_req_ready_i), and inflight + register occupancy < FIFO_DEPTH.
- Grant selection: first eligible SM searching ptr, ptr+1, … mod NUM_SM. req_ready_o is one-hot for the granted SM, combinational. On grant of SM k: ptr ← (k+1) mod NUM_SM, pending[k] ← 1, grantSM_o ← k.
- Request register: a grant in cycle N loads {k, warp, pc} and drives cache_req_valid_o=1 at N+1. PC_o and PCadd1_o are held stable until cache_req_ready_i.
- On cache handshake, {k, warp, pc} is pushed to the tag FIFO. inflight_o counts FIFO entries.
- Response: cache_rsp_valid_i in cycle M pops the FIFO head (SM j) and loads slot j. rsp_valid_o[j]=1 at M+1, with packets {instruction0_i, pc} and {instruction1_i, pc+1}.
- Slot j holds while stall_i[j]=1. In a cycle with rsp_valid_o[j]=1 and stall_i[j]=0, the slot is consumed: rsp_valid_o[j] and pending[j] clear next cycle. SM j is eligible again in that same next cycle.
- At most one outstanding request per SM, so a slot can never be overwritten.
- Push and pop in the same cycle: inflight_o is unchanged.
- cache_rsp_valid_i with FIFO empty: response ignored, err_o ← 1 until reset.
- Pointers wrap mod FIFO_DEPTH.

Optional Feature:
- Macro FETCH_ARB_PERF_CNT_EN.
- Defined: adds output perf_grant_o (NUM_SM*32) with a per-SM saturating grant counter, and output perf_stall_o (NUM_SM*32) with a per-SM saturating count of cycles where rsp_valid_o & stall_i. Both reset to 0 and stick at 0xFFFFFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- All 4 SMs request continuously, cache ready=1, response 2 cycles after each request → grant order 0,1,2,3,0 …; each SM receives exactly one response per grant.
- SM2 requests pc=0xFFFFFFFF, warp=5 → PC_o=0xFFFFFFFF, PCadd1_o=0; instPacket1_o for SM2 holds {inst1, 0x00000000}; rsp_warp_o for SM2 = 5.
- cache_req_ready_i=0 for 10 cycles → PC_o stable, cache_req_valid_o=1, at most one further grant; inflight_o unchanged.
- Hold stall_i[1]=1 for 5 cycles after SM1's response → rsp_valid_o[1] and packets held; SM1 not re-granted until 1 cycle after stall_i[1] drops.
- Hold the cache response until FIFO_DEPTH requests are in flight → inflight_o=4 and req_ready_o=0 until the first response arrives; then a grant occurs.
- Pulse cache_rsp_valid_i after reset with no request → err_o=1 and stays 1; assert reset low mid-traffic → all outputs 0 asynchronously.
